// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: free-running raster generator producing pixel/line coordinates, sync and DEN.
// Every output is registered and shows the position the counters held before the advancing edge.
module lcd_timing_gen #(
   parameter int unsigned H_ACTIVE = 32'd800,
   parameter int unsigned H_FP     = 32'd40,
   parameter int unsigned H_SYNC   = 32'd48,
   parameter int unsigned H_BP     = 32'd40,
   parameter int unsigned V_ACTIVE = 32'd480,
   parameter int unsigned V_FP     = 32'd13,
   parameter int unsigned V_SYNC   = 32'd3,
   parameter int unsigned V_BP     = 32'd29,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        lcd_hsync,
   output logic        lcd_vsync,
   output logic        lcd_den,
   output logic        line_start,
   output logic        frame_start
);
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [15:0] L_H_ACT  = 16'(H_ACTIVE);
   localparam logic [15:0] L_HS_BEG = 16'(H_ACTIVE + H_FP);
   localparam logic [15:0] L_HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [15:0] L_H_LAST = 16'(H_TOTAL - 32'd1);
   localparam logic [15:0] L_V_ACT  = 16'(V_ACTIVE);
   localparam logic [15:0] L_VS_BEG = 16'(V_ACTIVE + V_FP);
   localparam logic [15:0] L_VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [15:0] L_V_LAST = 16'(V_TOTAL - 32'd1);

   logic [15:0] r_h_cnt;
   logic [15:0] r_v_cnt;
   logic [15:0] r_x;
   logic [15:0] r_y;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_den;
   logic        r_line_start;
   logic        r_frame_start;

   logic        w_h_wrap;
   logic [15:0] w_h_next;
   logic [15:0] w_v_next;
   logic        w_den;
   logic        w_hsync_lvl;
   logic        w_vsync_lvl;

   // Next counter values and pin decodes from the current (pre-increment) position
   always_comb begin
      w_h_wrap = (r_h_cnt == L_H_LAST);
      w_h_next = r_h_cnt + 16'd1;
      w_v_next = r_v_cnt;
      if (w_h_wrap) begin
         w_h_next = 16'd0;
         if (r_v_cnt == L_V_LAST) begin
            w_v_next = 16'd0;
         end else begin
            w_v_next = r_v_cnt + 16'd1;
         end
      end else begin
         w_v_next = r_v_cnt;
      end
      w_den = (r_h_cnt < L_H_ACT) && (r_v_cnt < L_V_ACT);
      if ((r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END)) begin
         w_hsync_lvl = HS_POL;
      end else begin
         w_hsync_lvl = ~HS_POL;
      end
      // VSYNC depends only on v, so it can only change alongside an x==0 presentation
      if ((r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END)) begin
         w_vsync_lvl = VS_POL;
      end else begin
         w_vsync_lvl = ~VS_POL;
      end
   end

   // Raster counters and registered outputs; strobes drop whenever the raster is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_cnt       <= 16'd0;
         r_v_cnt       <= 16'd0;
         r_x           <= 16'd0;
         r_y           <= 16'd0;
         r_hsync       <= ~HS_POL;
         r_vsync       <= ~VS_POL;
         r_den         <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (ce) begin
         r_h_cnt       <= w_h_next;
         r_v_cnt       <= w_v_next;
         r_x           <= r_h_cnt;
         r_y           <= r_v_cnt;
         r_hsync       <= w_hsync_lvl;
         r_vsync       <= w_vsync_lvl;
         r_den         <= w_den;
         r_line_start  <= (r_h_cnt == 16'd0);
         r_frame_start <= (r_h_cnt == 16'd0) && (r_v_cnt == 16'd0);
      end else begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

   assign x           = r_x;
   assign y           = r_y;
   assign lcd_hsync   = r_hsync;
   assign lcd_vsync   = r_vsync;
   assign lcd_den     = r_den;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed bench for lcd_timing_gen, one default-timing instance and one
// small inverted-polarity instance used for frame-level wrap and period checks.
module tb_lcd_timing_gen;
   logic clk;
   logic rst_a, ce_a, rst_b, ce_b;

   logic [15:0] x_a, y_a, x_b, y_b;
   logic        hs_a, vs_a, den_a, ls_a, fs_a;
   logic        hs_b, vs_b, den_b, ls_b, fs_b;

   int n_asserts;
   int n_fail;
   int cyc;

   lcd_timing_gen u_dut_a (
      .clk(clk), .rst(rst_a), .ce(ce_a),
      .x(x_a), .y(y_a), .lcd_hsync(hs_a), .lcd_vsync(vs_a), .lcd_den(den_a),
      .line_start(ls_a), .frame_start(fs_a)
   );

   // Small raster: H_TOTAL=15 (hsync h=10..12), V_TOTAL=11 (vsync v=8..9), frame = 165 clks
   lcd_timing_gen #(
      .H_ACTIVE(32'd8), .H_FP(32'd2), .H_SYNC(32'd3), .H_BP(32'd2),
      .V_ACTIVE(32'd6), .V_FP(32'd2), .V_SYNC(32'd2), .V_BP(32'd1),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) u_dut_b (
      .clk(clk), .rst(rst_b), .ce(ce_b),
      .x(x_b), .y(y_b), .lcd_hsync(hs_b), .lcd_vsync(vs_b), .lcd_den(den_b),
      .line_start(ls_b), .frame_start(fs_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      int hs_low;
      int last_fs;
      int n_fs;
      n_asserts = 0;
      n_fail = 0;
      cyc = 0;
      rst_a = 1'b1; ce_a = 1'b1;
      rst_b = 1'b1; ce_b = 1'b1;

      // Reset with ce=1: reset wins
      step();
      chk_eq("rst_x", x_a, 0);
      chk_eq("rst_y", y_a, 0);
      chk_eq("rst_den", den_a, 0);
      chk_eq("rst_hs", hs_a, 1);
      chk_eq("rst_vs", vs_a, 1);
      chk_eq("rst_ls", ls_a, 0);
      chk_eq("rst_fs", fs_a, 0);
      chk_eq("rst_b_hs", hs_b, 0);
      chk_eq("rst_b_vs", vs_b, 0);
      chk_eq("rst_b_den", den_b, 0);

      // First edges after reset
      rst_a = 1'b0;
      step();
      chk_eq("e1_x", x_a, 0);
      chk_eq("e1_y", y_a, 0);
      chk_eq("e1_den", den_a, 1);
      chk_eq("e1_ls", ls_a, 1);
      chk_eq("e1_fs", fs_a, 1);
      chk_eq("e1_hs", hs_a, 1);
      chk_eq("e1_vs", vs_a, 1);
      step();
      chk_eq("e2_x", x_a, 1);
      chk_eq("e2_ls", ls_a, 0);
      chk_eq("e2_fs", fs_a, 0);

      // Line 0 scan
      hs_low = 0;
      for (int i = 2; i < 928; i++) begin
         step();
         chk_eq("line_x", x_a, i);
         if (hs_a == 1'b0) hs_low++;
         if (i == 799) chk_eq("den_799", den_a, 1);
         if (i == 800) chk_eq("den_800", den_a, 0);
         if (i == 839) chk_eq("hs_839", hs_a, 1);
         if (i == 840) chk_eq("hs_840", hs_a, 0);
         if (i == 887) chk_eq("hs_887", hs_a, 0);
         if (i == 888) chk_eq("hs_888", hs_a, 1);
         if (i == 927) chk_eq("vs_927", vs_a, 1);
      end
      chk_eq("hs_low_cnt", hs_low, 48);
      step();
      chk_eq("wrap_x", x_a, 0);
      chk_eq("wrap_y", y_a, 1);
      chk_eq("wrap_ls", ls_a, 1);
      chk_eq("wrap_fs", fs_a, 0);
      chk_eq("wrap_den", den_a, 1);

      // One-cycle stall right on a line-start strobe
      ce_a = 1'b0;
      step();
      chk_eq("st0_x", x_a, 0);
      chk_eq("st0_ls", ls_a, 0);
      ce_a = 1'b1;
      step();
      chk_eq("st0_rel_x", x_a, 1);
      chk_eq("st0_rel_y", y_a, 1);
      chk_eq("st0_rel_ls", ls_a, 0);

      // Advance from (1,1) to (799,10): 9*928 + 798 edges
      for (int i = 0; i < 9150; i++) step();
      chk_eq("pre_st_x", x_a, 799);
      chk_eq("pre_st_y", y_a, 10);
      chk_eq("pre_st_den", den_a, 1);
      ce_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_eq("st_x", x_a, 799);
         chk_eq("st_y", y_a, 10);
         chk_eq("st_den", den_a, 1);
         chk_eq("st_hs", hs_a, 1);
         chk_eq("st_ls", ls_a, 0);
         chk_eq("st_fs", fs_a, 0);
      end
      ce_a = 1'b1;
      step();
      chk_eq("rel_x", x_a, 800);
      chk_eq("rel_y", y_a, 10);
      chk_eq("rel_den", den_a, 0);
      step();
      chk_eq("rel2_x", x_a, 801);

      // Mid-frame reset on the default instance
      rst_a = 1'b1;
      step();
      chk_eq("mrst_x", x_a, 0);
      chk_eq("mrst_y", y_a, 0);
      chk_eq("mrst_den", den_a, 0);
      chk_eq("mrst_hs", hs_a, 1);
      chk_eq("mrst_vs", vs_a, 1);
      rst_a = 1'b0;
      step();
      chk_eq("mrst_fs", fs_a, 1);
      chk_eq("mrst_den1", den_a, 1);

      // Small inverted-polarity instance: two full frames position by position
      rst_b = 1'b0;
      last_fs = 0;
      n_fs = 0;
      for (int f = 0; f < 2; f++) begin
         for (int v = 0; v < 11; v++) begin
            for (int h = 0; h < 15; h++) begin
               step();
               chk_eq("b_x", x_b, h);
               chk_eq("b_y", y_b, v);
               chk_eq("b_den", den_b, (h < 8) && (v < 6));
               chk_eq("b_hs", hs_b, (h >= 10) && (h < 13));
               chk_eq("b_vs", vs_b, (v >= 8) && (v < 10));
               chk_eq("b_ls", ls_b, h == 0);
               chk_eq("b_fs", fs_b, (h == 0) && (v == 0));
               if (fs_b) begin
                  if (n_fs > 0) chk_eq("b_period", cyc - last_fs, 165);
                  last_fs = cyc;
                  n_fs++;
               end
            end
         end
      end
      step();
      chk_eq("b_fwrap_x", x_b, 0);
      chk_eq("b_fwrap_y", y_b, 0);
      chk_eq("b_fwrap_fs", fs_b, 1);
      chk_eq("b_period2", cyc - last_fs, 165);
      chk_eq("b_fs_count", n_fs, 2);

      // Move to (5,4) and reset mid-frame
      for (int i = 0; i < 65; i++) step();
      chk_eq("b_pre_x", x_b, 5);
      chk_eq("b_pre_y", y_b, 4);
      chk_eq("b_pre_den", den_b, 1);
      rst_b = 1'b1;
      step();
      chk_eq("b_mrst_x", x_b, 0);
      chk_eq("b_mrst_y", y_b, 0);
      chk_eq("b_mrst_den", den_b, 0);
      chk_eq("b_mrst_hs", hs_b, 0);
      chk_eq("b_mrst_vs", vs_b, 0);
      chk_eq("b_mrst_fs", fs_b, 0);
      rst_b = 1'b0;
      step();
      chk_eq("b_mrst_fs1", fs_b, 1);
      chk_eq("b_mrst_ls1", ls_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
